// File: rtl/riscv_pkg.sv
// Shared constants, ALU opcodes and ID/EX stage state encoding.
// The optional operand forwarding path is enabled by ID_EX_FORWARDING_EN.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand selector: immediate, MEM/WB forwarded value, or register data.
// Forwarding is compiled in only when ID_EX_FORWARDING_EN is defined.
module operand_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rs_data_i,
  input  logic              use_imm_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              fwd_mem_we_i,
  input  logic [REG_AW-1:0] fwd_mem_rd_i,
  input  logic [XLEN-1:0]   fwd_mem_data_i,
  input  logic              fwd_wb_we_i,
  input  logic [REG_AW-1:0] fwd_wb_rd_i,
  input  logic [XLEN-1:0]   fwd_wb_data_i,
  output logic [XLEN-1:0]   op_o
);

`ifdef ID_EX_FORWARDING_EN
  logic nz;
  logic mem_hit;
  logic wb_hit;

  assign nz      = rs_addr_i != '0;
  assign mem_hit = fwd_mem_we_i && (fwd_mem_rd_i == rs_addr_i) && nz;
  assign wb_hit  = fwd_wb_we_i && (fwd_wb_rd_i == rs_addr_i) && nz;

  // Immediate beats forwarding; MEM is younger than WB so it wins.
  always_comb begin
    op_o = rs_data_i;
    unique case (1'b1)
      use_imm_i:                       op_o = imm_i;
      !use_imm_i && mem_hit:           op_o = fwd_mem_data_i;
      !use_imm_i && !mem_hit && wb_hit: op_o = fwd_wb_data_i;
      default:                         op_o = rs_data_i;
    endcase
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{rs_addr_i, fwd_mem_we_i, fwd_mem_rd_i,
                        fwd_mem_data_i, fwd_wb_we_i, fwd_wb_rd_i,
                        fwd_wb_data_i};

  assign op_o = use_imm_i ? imm_i : rs_data_i;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: two-entry skid buffer with operand selection.
// Define ID_EX_FORWARDING_EN to forward MEM/WB results into the operands.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        alu_op_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              alu_src_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic              fwd_mem_we_i,
  input  logic [REG_AW-1:0] fwd_mem_rd_i,
  input  logic [XLEN-1:0]   fwd_mem_data_i,
  input  logic              fwd_wb_we_i,
  input  logic [REG_AW-1:0] fwd_wb_rd_i,
  input  logic [XLEN-1:0]   fwd_wb_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [3:0]        alu_op_o,
  output logic [XLEN-1:0]   a_o,
  output logic [XLEN-1:0]   b_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic [15:0]       stall_cnt_o
);

  typedef struct packed {
    logic [3:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [REG_AW-1:0] rd;
    logic              we;
  } entry_t;

  stage_state_e state_q;
  entry_t       out_q;
  entry_t       skid_q;
  entry_t       new_d;
  logic         valid_q;
  logic         ready_q;
  logic [15:0]  stall_q;
  logic         accept;
  logic         xfer;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux_a (
    .rs_addr_i      (rs1_addr_i),
    .rs_data_i      (rs1_data_i),
    .use_imm_i      (1'b0),
    .imm_i          (imm_i),
    .fwd_mem_we_i   (fwd_mem_we_i),
    .fwd_mem_rd_i   (fwd_mem_rd_i),
    .fwd_mem_data_i (fwd_mem_data_i),
    .fwd_wb_we_i    (fwd_wb_we_i),
    .fwd_wb_rd_i    (fwd_wb_rd_i),
    .fwd_wb_data_i  (fwd_wb_data_i),
    .op_o           (op_a)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux_b (
    .rs_addr_i      (rs2_addr_i),
    .rs_data_i      (rs2_data_i),
    .use_imm_i      (alu_src_i),
    .imm_i          (imm_i),
    .fwd_mem_we_i   (fwd_mem_we_i),
    .fwd_mem_rd_i   (fwd_mem_rd_i),
    .fwd_mem_data_i (fwd_mem_data_i),
    .fwd_wb_we_i    (fwd_wb_we_i),
    .fwd_wb_rd_i    (fwd_wb_rd_i),
    .fwd_wb_data_i  (fwd_wb_data_i),
    .op_o           (op_b)
  );

  assign accept = valid_i && ready_q;
  assign xfer   = valid_q && ready_i;

  always_comb begin
    new_d    = '0;
    new_d.op = alu_op_i;
    new_d.a  = op_a;
    new_d.b  = op_b;
    new_d.rd = rd_addr_i;
    new_d.we = reg_write_i;
  end

  // Stall counter keeps running across flushes; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      stall_q <= '0;
    end else begin
      if (valid_q && !ready_i && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
      if (flush_i) begin
        state_q <= ST_EMPTY;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              out_q   <= new_d;
              valid_q <= 1'b1;
              state_q <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (accept && xfer) begin
              out_q <= new_d;
            end else if (accept) begin
              skid_q  <= new_d;
              ready_q <= 1'b0;
              state_q <= ST_SKID;
            end else if (xfer) begin
              valid_q <= 1'b0;
              state_q <= ST_EMPTY;
            end
          end
          ST_SKID: begin
            if (xfer) begin
              out_q   <= skid_q;
              ready_q <= 1'b1;
              state_q <= ST_FULL;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign alu_op_o    = out_q.op;
  assign a_o         = out_q.a;
  assign b_o         = out_q.b;
  assign rd_addr_o   = out_q.rd;
  assign reg_write_o = out_q.we;
  assign stall_cnt_o = stall_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have the following ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- reset_n_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard all held entries.
- valid_i  in  1  upstream decoded instruction present.
- ready_o  out  1  stage can accept; registered.
- alu_op_i  in  4  ALU operation: ADD=0000, SUB=0001, OR=0010, SLL=0011.
- rs1_addr_i / rs2_addr_i  in  REG_AW  source register addresses.
- rs1_data_i / rs2_data_i  in  XLEN  register-file read data.
- imm_i  in  XLEN  sign-extended immediate.
- alu_src_i  in  1  1 = operand B from imm_i.
- rd_addr_i  in  REG_AW  destination register.
- reg_write_i  in  1  destination write enable.
- fwd_mem_we_i, fwd_mem_rd_i, fwd_mem_data_i  in  1/REG_AW/XLEN  MEM-stage forward source.
- fwd_wb_we_i, fwd_wb_rd_i, fwd_wb_data_i  in  1/REG_AW/XLEN  WB-stage forward source.
- valid_o  out  1  entry presented to ALU.
- ready_i  in  1  ALU/EX side accepts entry.
- alu_op_o  out  4  held operation.
- a_o, b_o  out  XLEN  ALU operands A and B.
- rd_addr_o, reg_write_o  out  REG_AW/1  held destination info.
- stall_cnt_o  out  16  saturating count of back-pressure cycles.

Function
REQ-004 SHALL accept an entry on a cycle with valid_i && ready_o, and transfer one on valid_o && ready_i.
REQ-005 SHALL hold two entries: an output register and a skid register; FSM states EMPTY, FULL, SKID.
REQ-006 EMPTY: accept -> FULL.
REQ-007 FULL: accept and transfer -> FULL, new entry into output register; accept only -> SKID, entry into skid register; transfer only -> EMPTY.
REQ-008 SKID: transfer -> FULL, skid moves to output register; no accept in SKID.
REQ-009 SHALL drive ready_o = 1 in EMPTY and FULL, 0 in SKID, from registered state only.
REQ-010 SHALL keep all outputs stable while valid_o && !ready_i.
REQ-011 SHALL compute operand A from rs1 and operand B from imm_i if alu_src_i = 1 else rs2, at capture time.
REQ-012 Forwarding: MEM source wins over WB; a source matches when we = 1, rd = rs address, and rd != 0; register 0 never forwarded.
REQ-013 Operand B SHALL not be forwarded when alu_src_i = 1.
REQ-014 alu_op_i values outside 0000-0011 SHALL pass through unmodified.
REQ-015 flush_i SHALL force EMPTY next cycle, overriding a simultaneous accept or transfer.
REQ-016 stall_cnt_o SHALL increment each cycle with valid_o && !ready_i, saturate at 16'hFFFF, and be unaffected by flush_i.

Reset
REQ-017 On reset_n_i = 0 at a clock edge: state EMPTY, valid_o = 0, ready_o = 1, all data outputs 0, stall_cnt_o = 0.
REQ-018 Reset SHALL override flush_i and any in-flight handshake.

Configuration
REQ-019 With ID_EX_FORWARDING_EN defined, operands SHALL be selected as in REQ-012.
REQ-020 Without ID_EX_FORWARDING_EN, rs1_data_i/rs2_data_i SHALL be used unmodified and all fwd_* inputs SHALL be ignored.
REQ-021 The port list SHALL be identical in both configurations.

Structure
REQ-022 Shared package riscv_pkg SHALL hold XLEN, REG_AW, the ALU opcode constants and the stage state encoding.
REQ-023 Operand selection SHALL be a combinational sub-module operand_fwd_mux, instantiated twice.

Verification
REQ-024 Stream: rs1=5, rs2=7, ADD, ready_i=1 held -> one entry per cycle; a_o=5, b_o=7 one cycle after accept.
REQ-025 Back-pressure: ready_i=0 for 3 cycles with 2 entries pushed -> SKID, ready_o=0, stall_cnt_o=3, order preserved on release.
REQ-026 Forward: rs1_addr=3, MEM rd=3 data=0xAAAA, WB rd=3 data=0x5555 -> a_o=0xAAAA; rd=0 -> a_o=rs1_data_i.
REQ-027 alu_src_i=1, imm_i=0xFFFFFFF0, WB rd matches rs2 -> b_o=0xFFFFFFF0.
REQ-028 flush_i in SKID with simultaneous valid_i -> next cycle EMPTY, valid_o=0, ready_o=1.
REQ-029 reset_n_i=0 mid-SKID -> all outputs at reset values next edge; rerun with ID_EX_FORWARDING_EN undefined -> REQ-026 gives a_o=rs1_data_i.
